// File: rtl/vote_bcd_converter.sv
// -----------------------------------------------------------------------------
// vote_bcd_converter
//
// Multi-channel binary-to-BCD converter for the tally display path. A start
// request picks one candidate's vote count, runs it through a sequential
// shift-add-3 (double-dabble) engine, and presents registered BCD digits with
// a leading-zero blanking mask and an overflow flag.
//
// Parameters
//   NUM_CH      number of candidate channels (>=1)
//   CNT_W       width of each vote count in bits (>=1)
//   NUM_DIGITS  number of BCD digits produced (>=1), digit 0 = ones
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high
//   sel       in   channel select, lowest set index wins (none set -> value 0)
//   counts    in   flattened counts, ch i = counts[i*CNT_W +: CNT_W]
//   start     in   conversion request, only honoured while idle
//   busy      out  conversion in progress
//   done      out  one-cycle pulse, result registers were just updated
//   bcd       out  result, digit i = bcd[4*i +: 4]
//   digit_en  out  leading-zero blank mask, 1 = display digit (bit 0 always 1)
//   overflow  out  count exceeded 10^NUM_DIGITS-1 (bcd then reads all nines)
//   ch_idx    out  channel the current result came from
// -----------------------------------------------------------------------------
module vote_bcd_converter #(
  parameter  int NUM_CH     = 3,
  parameter  int CNT_W      = 10,
  parameter  int NUM_DIGITS = 4,
  localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         sel,
  input  logic [NUM_CH*CNT_W-1:0]   counts,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      overflow,
  output logic [IDX_W-1:0]          ch_idx
);

  localparam int DIG_W    = 4 * NUM_DIGITS;
  localparam int SCR_W    = DIG_W + CNT_W;
  localparam int CNT_BITS = $clog2(CNT_W + 1);

  localparam logic [CNT_BITS-1:0]   LAST_SHIFT = CNT_BITS'(CNT_W - 1);
  localparam logic [NUM_DIGITS-1:0] EN_RESET   = NUM_DIGITS'(1);
  localparam logic [DIG_W-1:0]      ALL_NINES  = {NUM_DIGITS{4'h9}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  // Conversion scratch: BCD digit field above the binary value being consumed.
  logic [DIG_W-1:0]    scr_dig;
  logic [CNT_W-1:0]    scr_val;
  logic                scr_ovf;
  logic [IDX_W-1:0]    cap_idx;
  logic [CNT_BITS-1:0] shift_cnt;

  logic                capture;
  logic                last_shift;

  logic [CNT_W-1:0]    pick_val;
  logic [IDX_W-1:0]    pick_idx;

  logic [DIG_W-1:0]    adj_dig;
  logic [SCR_W-1:0]    step_in;
  logic [SCR_W-1:0]    step_out;
  logic [DIG_W-1:0]    step_dig;
  logic [CNT_W-1:0]    step_val;
  logic                step_ovf;

  logic [NUM_DIGITS-1:0] res_en;
  logic                  seen_nz;

  assign capture    = (state == IDLE) && start;
  assign last_shift = (state == SHIFT) && (shift_cnt == LAST_SHIFT);
  assign busy       = (state == SHIFT);

  // ---------------------------------------------------------------------------
  // Channel pick: scanning from the top down lets the lowest set bit override.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_val = '0;
    pick_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sel[i]) begin
        pick_val = counts[i*CNT_W +: CNT_W];
        pick_idx = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {digits,value} field left. A digit of 5..9 becomes 8..12 after the add,
  // so the top digit's bit 3 is exactly the "value no longer fits" condition.
  // ---------------------------------------------------------------------------
  always_comb begin
    adj_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scr_dig[4*i +: 4] >= 4'd5) begin
        adj_dig[4*i +: 4] = scr_dig[4*i +: 4] + 4'd3;
      end else begin
        adj_dig[4*i +: 4] = scr_dig[4*i +: 4];
      end
    end
  end

  assign step_in  = {adj_dig, scr_val};
  assign step_out = {step_in[SCR_W-2:0], 1'b0};
  assign step_dig = step_out[SCR_W-1 -: DIG_W];
  assign step_val = step_out[CNT_W-1:0];
  assign step_ovf = scr_ovf | step_in[SCR_W-1];

  // ---------------------------------------------------------------------------
  // Leading-zero mask for the digits produced by the final step: a digit is
  // shown when it or any more significant digit is nonzero; the ones digit is
  // always shown so a zero count reads "0".
  // ---------------------------------------------------------------------------
  always_comb begin
    res_en  = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz   = seen_nz | (step_dig[4*i +: 4] != 4'd0);
      res_en[i] = seen_nz;
    end
    res_en[0] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)      state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers. Reset clears everything, so a reset during
  // a conversion drops it without a done pulse or a result update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr_dig   <= '0;
      scr_val   <= '0;
      scr_ovf   <= 1'b0;
      cap_idx   <= '0;
      shift_cnt <= '0;
      done      <= 1'b0;
      bcd       <= '0;
      digit_en  <= EN_RESET;
      overflow  <= 1'b0;
      ch_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        scr_dig   <= '0;
        scr_val   <= pick_val;
        scr_ovf   <= 1'b0;
        cap_idx   <= pick_idx;
        shift_cnt <= '0;
      end else if (state == SHIFT) begin
        scr_dig   <= step_dig;
        scr_val   <= step_val;
        scr_ovf   <= step_ovf;
        shift_cnt <= shift_cnt + CNT_BITS'(1);
        if (last_shift) begin
          done   <= 1'b1;
          ch_idx <= cap_idx;
          if (step_ovf) begin
            bcd      <= ALL_NINES;
            digit_en <= '1;
            overflow <= 1'b1;
          end else begin
            bcd      <= step_dig;
            digit_en <= res_en;
            overflow <= 1'b0;
          end
        end
      end
    end
  end

endmodule
